axi2apb_apb_ctrl: RTL

APB master sequencer for the AXI-to-APB bridge. It pops one command at a time from the bridge command FIFO and decodes the target slave from the top address bits. It runs the APB SETUP/ACCESS protocol, collects the AXI write beat, and returns the AXI B or R response. It sits between the command FIFO outputs (`cmd_*`, `finish_*`) and the APB slave bus.

---
 rtl/axi2apb_apb_ctrl_pkg.sv | 18 +
 rtl/axi2apb_slv_mux.sv | 31 +++
 rtl/axi2apb_apb_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/axi2apb_apb_ctrl_pkg.sv
// rtl/axi2apb_apb_ctrl_pkg.sv - shared constants and state encoding for the APB sequencer
package axi2apb_apb_ctrl_pkg;

  localparam int DATA_BITS = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_W = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/axi2apb_slv_mux.sv
// rtl/axi2apb_slv_mux.sv - combinational selection of the addressed slave's return signals
module axi2apb_slv_mux
  import axi2apb_apb_ctrl_pkg::*;
#(
  parameter int SLV_NUM  = 4,
  parameter int SLV_BITS = 2
) (
  input  logic [SLV_BITS-1:0]          slv_i,
  input  logic [SLV_NUM*DATA_BITS-1:0] prdata_i,
  input  logic [SLV_NUM-1:0]           pready_i,
  input  logic [SLV_NUM-1:0]           pslverr_i,
  output logic [DATA_BITS-1:0]         prdata_o,
  output logic                         pready_o,
  output logic                         pslverr_o
);

  // An out-of-range index selects nothing: all outputs stay zero.
  always_comb begin
    prdata_o  = '0;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    for (int k = 0; k < SLV_NUM; k++) begin
      if (slv_i == SLV_BITS'(k)) begin
        prdata_o  = prdata_i[k*DATA_BITS +: DATA_BITS];
        pready_o  = pready_i[k];
        pslverr_o = pslverr_i[k];
      end
    end
  end

endmodule

// File: rtl/axi2apb_apb_ctrl.sv
// rtl/axi2apb_apb_ctrl.sv - APB master sequencer: one FIFO command per APB transfer plus AXI response
module axi2apb_apb_ctrl
  import axi2apb_apb_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = 24,
  parameter int ID_BITS   = 4,
  parameter int SLV_NUM   = 4,
  parameter int SLV_BITS  = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_empty,
  input  logic                         cmd_read,
  input  logic                         cmd_err,
  input  logic [ID_BITS-1:0]           cmd_id,
  input  logic [ADDR_BITS-1:0]         cmd_addr,
  output logic                         finish_wr,
  output logic                         finish_rd,
  input  logic                         WVALID,
  input  logic                         WLAST,
  input  logic [DATA_BITS-1:0]         WDATA,
  output logic                         WREADY,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic [ID_BITS-1:0]           BID,
  output logic [1:0]                   BRESP,
  output logic                         RVALID,
  output logic                         RLAST,
  input  logic                         RREADY,
  output logic [ID_BITS-1:0]           RID,
  output logic [DATA_BITS-1:0]         RDATA,
  output logic [1:0]                   RRESP,
  output logic [SLV_NUM-1:0]           psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_BITS-1:0]         paddr,
  output logic [DATA_BITS-1:0]         pwdata,
  input  logic [SLV_NUM*DATA_BITS-1:0] prdata,
  input  logic [SLV_NUM-1:0]           pready,
  input  logic [SLV_NUM-1:0]           pslverr
);

  // Last ACCESS cycle index before the transfer is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e                 state_q;
  logic [SLV_NUM-1:0]     psel_q;
  logic                   penable_q;
  logic                   pwrite_q;
  logic [ADDR_BITS-1:0]   paddr_q;
  logic [DATA_BITS-1:0]   pwdata_q;
  logic [DATA_BITS-1:0]   rdata_q;
  logic [1:0]             resp_q;
  logic                   wready_q;
  logic                   bvalid_q;
  logic                   rvalid_q;
  logic [7:0]             cnt_q;

  logic [SLV_BITS-1:0]    slv;
  logic                   dec_miss;
  logic [SLV_NUM-1:0]     slv_onehot;
  logic [DATA_BITS-1:0]   sel_prdata;
  logic                   sel_pready;
  logic                   sel_pslverr;
  logic                   unused_wlast;

  // Single-beat commands: the last flag carries no information.
  assign unused_wlast = WLAST;

  assign slv      = cmd_addr[ADDR_BITS-1 -: SLV_BITS];
  assign dec_miss = ({1'b0, slv} >= (SLV_BITS+1)'(SLV_NUM));

  // Decode the slave index into the psel pattern driven during SETUP/ACCESS.
  always_comb begin
    slv_onehot = '0;
    for (int k = 0; k < SLV_NUM; k++) begin
      slv_onehot[k] = (slv == SLV_BITS'(k));
    end
  end

  axi2apb_slv_mux #(
    .SLV_NUM  (SLV_NUM),
    .SLV_BITS (SLV_BITS)
  ) u_slv_mux (
    .slv_i     (slv),
    .prdata_i  (prdata),
    .pready_i  (pready),
    .pslverr_i (pslverr),
    .prdata_o  (sel_prdata),
    .pready_o  (sel_pready),
    .pslverr_o (sel_pslverr)
  );

  // Command sequencer; every bus-facing control output is a register set on state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!cmd_empty) begin
            if (!cmd_read) begin
              state_q  <= ST_WAIT_W;
              wready_q <= 1'b1;
            end else if (cmd_err || dec_miss) begin
              state_q  <= ST_RESP;
              resp_q   <= cmd_err ? RESP_SLVERR : RESP_DECERR;
              rdata_q  <= '0;
              rvalid_q <= 1'b1;
            end else begin
              state_q  <= ST_SETUP;
              psel_q   <= slv_onehot;
              pwrite_q <= 1'b0;
              paddr_q  <= cmd_addr;
            end
          end
        end
        ST_WAIT_W: begin
          if (WVALID) begin
            pwdata_q <= WDATA;
            wready_q <= 1'b0;
            if (cmd_err || dec_miss) begin
              state_q  <= ST_RESP;
              resp_q   <= cmd_err ? RESP_SLVERR : RESP_DECERR;
              bvalid_q <= 1'b1;
            end else begin
              state_q  <= ST_SETUP;
              psel_q   <= slv_onehot;
              pwrite_q <= 1'b1;
              paddr_q  <= cmd_addr;
            end
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        ST_ACCESS: begin
          if (sel_pready) begin
            rdata_q   <= sel_prdata;
            resp_q    <= sel_pslverr ? RESP_SLVERR : RESP_OKAY;
            psel_q    <= '0;
            penable_q <= 1'b0;
            bvalid_q  <= ~cmd_read;
            rvalid_q  <= cmd_read;
            state_q   <= ST_RESP;
          end else if (cnt_q == TMO_LAST) begin
            resp_q    <= RESP_SLVERR;
            psel_q    <= '0;
            penable_q <= 1'b0;
            bvalid_q  <= ~cmd_read;
            rvalid_q  <= cmd_read;
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_RESP: begin
          if ((bvalid_q && BREADY) || (rvalid_q && RREADY)) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BID       = cmd_id;
  assign BRESP     = resp_q;
  assign RVALID    = rvalid_q;
  assign RLAST     = rvalid_q;
  assign RID       = cmd_id;
  assign RDATA     = rdata_q;
  assign RRESP     = resp_q;
  assign finish_wr = bvalid_q & BREADY;
  assign finish_rd = rvalid_q & RREADY;

endmodule
